datapath: RTL and testbench
===========================

// Module: datapath
// PURPOSE
//  32-bit single-bus CPU datapath: 16 GPRs, HI/LO, PC, IR, MAR, MDR, Inport, Y, 64-bit Z and a combinational ALU.
//  A shared 32-bit bus carries data between units. The control unit (or a bench) sequences it with one-hot *out
//  (bus source) and *in (load enable) strobes. Sits under the control unit and beside memory, which supplies Mdatain.
// PARAMETERS
//  none (fixed 32-bit word, 16 GPRs)
// PORTS
//  Clock          in  1   rising-edge clock
//  clear          in  1   reset: synchronous, active-high
//  Read           in  1   MDR input mux: 1=Mdatain, 0=bus
//  IncPC          in  1   ALU override: result = bus+1
//  opcode         in  5   ALU operation select
//  R0in..R15in    in  1 each  GPR load enables
//  HIin,LOin,Yin,Zin,PCin,IRin,MARin,MDRin,Inportin,Cin  in 1 each  register load enables
//  R0out..R15out  in  1 each  GPR bus-drive selects
//  HIout,LOout,Yout,Zhighout,Zlowout,PCout,IRout,MARout,MDRout,Inportout,Cout  in 1 each  bus-drive selects
//  Mdatain        in  32  memory read data
// BEHAVIOUR
//  - Bus is a combinational mux. Priority when several selects are high, first wins: R0..R15, HI, LO, Zhigh, Zlow,
//    PC, MDR, Inport, C, Y, IR, MAR. No select high -> bus = 0.
//  - Cout drives C_sext = sign-extend(IR[18:0]). Cin has no storage; it is accepted and ignored.
//  - Every register loads at posedge Clock when its *in is high. Source is the bus, except:
//    MDR loads Read ? Mdatain : bus; Z loads the 64-bit ALU result.
//  - clear at posedge: all registers (GPRs, HI, LO, PC, IR, MAR, MDR, Inport, Y, Z) = 0. clear beats any *in.
//  - Load latency is one edge: the bus value in cycle n is visible at the register output in cycle n+1.
//  - An *out and *in on the same register in one cycle: the register reloads its own value.
//  - ALU: A = Y, B = bus, result R[63:0]. IncPC=1 forces R = {32'b0, B+1} regardless of opcode.
//  - Opcodes (add/sub wrap mod 2^32, Zhigh=0 unless stated):
//    00011 add A+B | 00100 sub A-B | 00101 and | 00110 or | 00111 shr A>>B[4:0] | 01000 shra (arith)
//    01001 shl | 01010 ror A by B[4:0] | 01011 rol | 01111 mul: signed A*B, 64-bit in Z
//    10000 div: Zlow = A/B, Zhigh = A%B (signed); B=0 -> R=0 | 10001 neg -B | 10010 not ~B
//    any other opcode -> R = 0.
//  - Z holds its value until the next Zin or clear. Zhighout drives Z[63:32], Zlowout drives Z[31:0].
// CONFIGURATION
//  - DATAPATH_MULDIV_EN defined: mul/div implemented as above.
//  - DATAPATH_MULDIV_EN undefined: opcodes 01111 and 10000 produce R = 0; no multiplier/divider logic.
// STRUCTURE
//  - datapath_pkg: opcode localparams (OP_ADD..OP_NOT), word width 32, bus-select priority order.
//  - Sub-module alu (combinational: A, B, opcode, IncPC -> R[63:0]).
//  - Bus mux, register file and special registers are inline in datapath.
// TESTING
//  1 Load: Mdatain=4, Read+MDRin; then MDRout+R2in -> R2=4. Likewise R3=5, R1=8.
//  2 Fetch, PC=0: PCout+MARin+IncPC+Zin -> MAR=0, Zlow=1. Zlowout+PCin+Read+MDRin with Mdatain=0x18918000 ->
//    PC=1, MDR=0x18918000. MDRout+IRin -> IR=0x18918000.
//  3 add R1,R2,R3: R2out+Yin -> Y=4. R3out+opcode=00011+Zin -> Z=9. Zlowout+R1in -> R1=9 (was 8).
//  4 sub/shift: Y=5, bus=7, sub -> Zlow=0xFFFFFFFE. Y=0x80000000, bus=1, shra -> 0xC0000000; ror -> 0x40000000.
//  5 mul (macro on): Y=-3, bus=4 -> Z=0xFFFFFFFF_FFFFFFF4. div 17/5 -> Zlow=3, Zhigh=2. Macro off -> Z=0.
//  6 clear asserted together with R1in and a bus value -> all registers 0 after the edge; R1out -> bus=0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus CPU datapath.
// Contents:
//   WORD_W         data word width (32)
//   NUM_GPR        number of general-purpose registers (16)
//   OP_*           5-bit ALU opcode encodings
//   SRC_*          bus-source indices; a lower index wins when several selects are high
//   BUS_NUM_SRC    number of bus sources
package datapath_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned NUM_GPR = 16;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Bus priority order: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, Inport, C, Y, IR, MAR
    localparam int unsigned SRC_R0     = 0;
    localparam int unsigned SRC_HI     = 16;
    localparam int unsigned SRC_LO     = 17;
    localparam int unsigned SRC_ZHIGH  = 18;
    localparam int unsigned SRC_ZLOW   = 19;
    localparam int unsigned SRC_PC     = 20;
    localparam int unsigned SRC_MDR    = 21;
    localparam int unsigned SRC_INPORT = 22;
    localparam int unsigned SRC_C      = 23;
    localparam int unsigned SRC_Y      = 24;
    localparam int unsigned SRC_IR     = 25;
    localparam int unsigned SRC_MAR    = 26;
    localparam int unsigned BUS_NUM_SRC = 27;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU for the datapath.
// Ports:
//   a       in  32  operand A (Y register)
//   b       in  32  operand B (bus)
//   opcode  in  5   operation select
//   IncPC   in  1   forces result = {32'b0, b + 1}
//   r       out 64  result; upper half is zero except for mul/div
// Configuration: DATAPATH_MULDIV_EN enables the signed multiplier and divider;
// when undefined, mul/div opcodes return zero and no such logic is built.
module alu
    import datapath_pkg::*;
(
    input  logic [WORD_W-1:0]   a,
    input  logic [WORD_W-1:0]   b,
    input  logic [4:0]          opcode,
    input  logic                IncPC,
    output logic [2*WORD_W-1:0] r
);

    logic [4:0]          shamt;
    logic [2*WORD_W-1:0] dbl;
    logic [2*WORD_W-1:0] ror_full;
    logic [2*WORD_W-1:0] rol_full;

    assign shamt    = b[4:0];
    assign dbl      = {a, a};
    // Rotates are taken from a shifted copy of {a, a}, which also handles shamt = 0.
    assign ror_full = dbl >> shamt;
    assign rol_full = dbl << shamt;

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*WORD_W-1:0] prod;
    logic signed [WORD_W-1:0]   quo;
    logic signed [WORD_W-1:0]   rem;

    assign prod = $signed({{WORD_W{a[WORD_W-1]}}, a}) * $signed({{WORD_W{b[WORD_W-1]}}, b});
    assign quo  = (b == '0) ? '0 : $signed(a) / $signed(b);
    assign rem  = (b == '0) ? '0 : $signed(a) % $signed(b);
`endif

    always_comb begin
        r = '0;
        if (IncPC) begin
            r[WORD_W-1:0] = b + 32'd1;
        end else begin
            case (opcode)
                OP_ADD:  r[WORD_W-1:0] = a + b;
                OP_SUB:  r[WORD_W-1:0] = a - b;
                OP_AND:  r[WORD_W-1:0] = a & b;
                OP_OR:   r[WORD_W-1:0] = a | b;
                OP_SHR:  r[WORD_W-1:0] = a >> shamt;
                OP_SHRA: r[WORD_W-1:0] = $unsigned($signed(a) >>> shamt);
                OP_SHL:  r[WORD_W-1:0] = a << shamt;
                OP_ROR:  r[WORD_W-1:0] = ror_full[WORD_W-1:0];
                OP_ROL:  r[WORD_W-1:0] = rol_full[2*WORD_W-1:WORD_W];
`ifdef DATAPATH_MULDIV_EN
                OP_MUL:  r = $unsigned(prod);
                OP_DIV:  r = {$unsigned(rem), $unsigned(quo)};
`endif
                OP_NEG:  r[WORD_W-1:0] = -b;
                OP_NOT:  r[WORD_W-1:0] = ~b;
                default: r = '0;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// 32-bit single-bus CPU datapath: 16 GPRs, HI, LO, PC, IR, MAR, MDR, Inport, Y, 64-bit Z
// and a combinational ALU (A = Y, B = bus).
// Ports:
//   Clock                   in  1   rising-edge clock
//   clear                   in  1   synchronous active-high reset of all registers
//   Read                    in  1   MDR source: 1 = Mdatain, 0 = bus
//   IncPC                   in  1   ALU result forced to bus + 1
//   opcode                  in  5   ALU operation
//   R0in..R15in, HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin
//                           in  1   load enables (Cin has no storage)
//   R0out..R15out, HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout,
//   Inportout, Cout         in  1   bus-drive selects
//   Mdatain                 in  32  memory read data
// Configuration: DATAPATH_MULDIV_EN enables mul/div in the ALU.
module datapath
    import datapath_pkg::*;
(
    input  logic              Clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              IncPC,
    input  logic [4:0]        opcode,
    input  logic              R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic              R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic              HIin,  LOin,  Yin,   Zin,   PCin,  IRin,  MARin, MDRin,
    input  logic              Inportin, Cin,
    input  logic              R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic              R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic              HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout,
    input  logic              MDRout, Inportout, Cout,
    input  logic [WORD_W-1:0] Mdatain
);

    logic [NUM_GPR-1:0]     gpr_in;
    logic [NUM_GPR-1:0]     gpr_out;
    logic [WORD_W-1:0]      gpr_q [NUM_GPR];
    logic [WORD_W-1:0]      hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, inport_q, y_q;
    logic [2*WORD_W-1:0]    z_q;
    logic [2*WORD_W-1:0]    alu_r;
    logic [WORD_W-1:0]      c_sext;
    logic [WORD_W-1:0]      bus;
    logic [BUS_NUM_SRC-1:0] bus_sel;
    logic [WORD_W-1:0]      bus_src [BUS_NUM_SRC];
    logic                   unused_cin;

    assign gpr_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign gpr_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // C has no register; it is the sign-extended IR immediate field.
    assign c_sext     = {{(WORD_W-19){ir_q[18]}}, ir_q[18:0]};
    assign unused_cin = Cin;

    always_comb begin
        bus_sel = '0;
        for (int i = 0; i < NUM_GPR; i++) begin
            bus_sel[SRC_R0+i]         = gpr_out[i];
            bus_src[SRC_R0+i]         = gpr_q[i];
        end
        bus_sel[SRC_HI]     = HIout;     bus_src[SRC_HI]     = hi_q;
        bus_sel[SRC_LO]     = LOout;     bus_src[SRC_LO]     = lo_q;
        bus_sel[SRC_ZHIGH]  = Zhighout;  bus_src[SRC_ZHIGH]  = z_q[2*WORD_W-1:WORD_W];
        bus_sel[SRC_ZLOW]   = Zlowout;   bus_src[SRC_ZLOW]   = z_q[WORD_W-1:0];
        bus_sel[SRC_PC]     = PCout;     bus_src[SRC_PC]     = pc_q;
        bus_sel[SRC_MDR]    = MDRout;    bus_src[SRC_MDR]    = mdr_q;
        bus_sel[SRC_INPORT] = Inportout; bus_src[SRC_INPORT] = inport_q;
        bus_sel[SRC_C]      = Cout;      bus_src[SRC_C]      = c_sext;
        bus_sel[SRC_Y]      = Yout;      bus_src[SRC_Y]      = y_q;
        bus_sel[SRC_IR]     = IRout;     bus_src[SRC_IR]     = ir_q;
        bus_sel[SRC_MAR]    = MARout;    bus_src[SRC_MAR]    = mar_q;
    end

    // Scan from lowest priority upward so the lowest-index active select is applied last.
    always_comb begin
        bus = '0;
        for (int i = BUS_NUM_SRC - 1; i >= 0; i--) begin
            if (bus_sel[i]) begin
                bus = bus_src[i];
            end
        end
    end

    alu u_alu (
        .a      (y_q),
        .b      (bus),
        .opcode (opcode),
        .IncPC  (IncPC),
        .r      (alu_r)
    );

    always_ff @(posedge Clock) begin
        if (clear) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q     <= '0;
            lo_q     <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            inport_q <= '0;
            y_q      <= '0;
            z_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (gpr_in[i]) gpr_q[i] <= bus;
            end
            if (HIin)     hi_q     <= bus;
            if (LOin)     lo_q     <= bus;
            if (PCin)     pc_q     <= bus;
            if (IRin)     ir_q     <= bus;
            if (MARin)    mar_q    <= bus;
            if (MDRin)    mdr_q    <= Read ? Mdatain : bus;
            if (Inportin) inport_q <= bus;
            if (Yin)      y_q      <= bus;
            if (Zin)      z_q      <= alu_r;
        end
    end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

    logic        Clock = 1'b0;
    logic        clear, Read, IncPC;
    logic [4:0]  opcode;
    logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
    logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in;
    logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin;
    logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
    logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout;
    logic        MDRout, Inportout, Cout;
    logic [31:0] Mdatain;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    datapath dut (
        .Clock(Clock), .clear(clear), .Read(Read), .IncPC(IncPC), .opcode(opcode),
        .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in),
        .R6in(R6in), .R7in(R7in), .R8in(R8in), .R9in(R9in), .R10in(R10in), .R11in(R11in),
        .R12in(R12in), .R13in(R13in), .R14in(R14in), .R15in(R15in),
        .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin),
        .MARin(MARin), .MDRin(MDRin), .Inportin(Inportin), .Cin(Cin),
        .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out), .R4out(R4out),
        .R5out(R5out), .R6out(R6out), .R7out(R7out), .R8out(R8out), .R9out(R9out),
        .R10out(R10out), .R11out(R11out), .R12out(R12out), .R13out(R13out),
        .R14out(R14out), .R15out(R15out),
        .HIout(HIout), .LOout(LOout), .Yout(Yout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .IRout(IRout), .MARout(MARout), .MDRout(MDRout),
        .Inportout(Inportout), .Cout(Cout), .Mdatain(Mdatain)
    );

    task automatic idle();
        clear = 0; Read = 0; IncPC = 0; opcode = 5'b0; Mdatain = 32'h0;
        {R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in} = '0;
        {R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in} = '0;
        {HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin} = '0;
        {R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out} = '0;
        {R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out} = '0;
        {HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout} = '0;
        {MDRout, Inportout, Cout} = '0;
    endtask

    // Apply the currently driven strobes across one rising edge, then release them.
    task automatic step();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // MDR <- val from memory, then move MDR into Y.
    task automatic load_y(input logic [31:0] val);
        Mdatain = val; Read = 1; MDRin = 1; step();
        MDRout = 1; Yin = 1; step();
    endtask

    // MDR <- b from memory, then Z <- ALU(Y, MDR) with the given opcode.
    task automatic alu_op(input logic [31:0] b, input logic [4:0] op);
        Mdatain = b; Read = 1; MDRin = 1; step();
        MDRout = 1; opcode = op; Zin = 1; step();
    endtask

    initial begin
        idle();
        clear = 1;
        step();
        check("reset_r1", dut.gpr_q[1], 0);
        check("reset_pc", dut.pc_q, 0);
        check("reset_z", dut.z_q, 0);
        #1 check("bus_idle", dut.bus, 0);

        // Register loads via MDR
        Mdatain = 32'd4; Read = 1; MDRin = 1; step();
        check("mdr_load", dut.mdr_q, 32'd4);
        MDRout = 1; R2in = 1; step();
        check("r2_load", dut.gpr_q[2], 32'd4);
        Mdatain = 32'd5; Read = 1; MDRin = 1; step();
        MDRout = 1; R3in = 1; step();
        check("r3_load", dut.gpr_q[3], 32'd5);
        Mdatain = 32'd8; Read = 1; MDRin = 1; step();
        MDRout = 1; R1in = 1; step();
        check("r1_load", dut.gpr_q[1], 32'd8);

        // Instruction fetch
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; step();
        check("fetch_mar", dut.mar_q, 0);
        check("fetch_z", dut.z_q, 64'd1);
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h18918000; step();
        check("fetch_pc", dut.pc_q, 32'd1);
        check("fetch_mdr", dut.mdr_q, 32'h18918000);
        MDRout = 1; IRin = 1; step();
        check("fetch_ir", dut.ir_q, 32'h18918000);
        Cout = 1; #1;
        check("c_sext", dut.bus, 32'h00018000);
        idle();

        // add R1, R2, R3
        R2out = 1; Yin = 1; step();
        check("add_y", dut.y_q, 32'd4);
        R3out = 1; opcode = 5'b00011; Zin = 1; step();
        check("add_z", dut.z_q, 64'd9);
        Zlowout = 1; R1in = 1; step();
        check("add_r1", dut.gpr_q[1], 32'd9);

        // Bus priority and self-reload
        R1out = 1; R2out = 1; #1;
        check("prio_r1_r2", dut.bus, 32'd9);
        idle();
        R2out = 1; HIout = 1; MDRout = 1; #1;
        check("prio_r2_hi", dut.bus, 32'd4);
        idle();
        PCout = 1; MARout = 1; IRout = 1; #1;
        check("prio_pc_ir", dut.bus, 32'd1);
        idle();
        R1out = 1; R1in = 1; step();
        check("self_reload", dut.gpr_q[1], 32'd9);

        // Sub, shifts, rotates, logic
        load_y(32'd5);
        alu_op(32'd7, 5'b00100);
        check("sub", dut.z_q, 64'h0000_0000_FFFF_FFFE);
        alu_op(32'd7, 5'b00000);
        check("bad_opcode", dut.z_q, 0);
        alu_op(32'd3, 5'b00101);
        check("and", dut.z_q, 64'd1);
        alu_op(32'd3, 5'b00110);
        check("or", dut.z_q, 64'd7);
        load_y(32'h8000_0000);
        alu_op(32'd1, 5'b01000);
        check("shra", dut.z_q, 64'hC000_0000);
        alu_op(32'd1, 5'b01010);
        check("ror", dut.z_q, 64'h4000_0000);
        alu_op(32'd1, 5'b01011);
        check("rol", dut.z_q, 64'd1);
        alu_op(32'd4, 5'b00111);
        check("shr", dut.z_q, 64'h0800_0000);
        alu_op(32'd1, 5'b01001);
        check("shl", dut.z_q, 0);
        alu_op(32'd0, 5'b10010);
        check("not", dut.z_q, 64'hFFFF_FFFF);
        alu_op(32'd1, 5'b10001);
        check("neg", dut.z_q, 64'hFFFF_FFFF);
        Mdatain = 32'd7; Read = 1; MDRin = 1; step();
        MDRout = 1; opcode = 5'b00011; IncPC = 1; Zin = 1; step();
        check("incpc", dut.z_q, 64'd8);

        // Multiply and divide
        load_y(32'hFFFF_FFFD);
        alu_op(32'd4, 5'b01111);
`ifdef DATAPATH_MULDIV_EN
        check("mul", dut.z_q, 64'hFFFF_FFFF_FFFF_FFF4);
`else
        check("mul", dut.z_q, 0);
`endif
        load_y(32'd17);
        alu_op(32'd5, 5'b10000);
        Zhighout = 1; #1;
`ifdef DATAPATH_MULDIV_EN
        check("div", dut.z_q, {32'd2, 32'd3});
        check("zhigh_bus", dut.bus, 32'd2);
`else
        check("div", dut.z_q, 0);
        check("zhigh_bus", dut.bus, 0);
`endif
        idle();
        alu_op(32'd0, 5'b10000);
        check("div_zero", dut.z_q, 0);

        // clear wins over a concurrent load
        Mdatain = 32'hDEAD_BEEF; Read = 1; MDRin = 1; step();
        clear = 1; MDRout = 1; R1in = 1; step();
        check("clr_r1", dut.gpr_q[1], 0);
        check("clr_mdr", dut.mdr_q, 0);
        check("clr_pc", dut.pc_q, 0);
        check("clr_ir", dut.ir_q, 0);
        check("clr_y", dut.y_q, 0);
        R1out = 1; #1;
        check("clr_bus", dut.bus, 0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
